// File: rtl/scratch_mem_arbiter_pkg.sv
// Shared definitions for the scratch memory arbiter: FSM state encoding,
// scratch memory geometry and the round-robin index search.
// Optional feature macro used by the top: ARB_TIMEOUT_EN.
package scratch_mem_arbiter_pkg;

    localparam int SCRATCH_ADDR_W = 12;
    localparam int SCRATCH_DATA_W = 32;

    // Widest requester vector the selector supports and the index width
    // needed to address it (gntIdx is always 3 bits wide).
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Returns the first set bit of req_vec found by scanning upward from
    // (ptr + 1) mod num_req with wrap-around. Returns 0 when nothing is set;
    // callers qualify the result with |req_vec.
    function automatic logic [IDX_W-1:0] rr_next_idx(
        input logic [MAX_REQ-1:0] req_vec,
        input logic [IDX_W-1:0]   ptr,
        input int                 num_req
    );
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand;
        logic             found;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % num_req);
            if (!found && (k <= num_req) && req_vec[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/scratch_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: given a request vector and the index
// of the last winner, returns the next winner as one-hot and as an index.
// Kept generic so other shared-resource arbiters can reuse it.
module scratch_mem_arbiter_rr_pick
    import scratch_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    logic [MAX_REQ-1:0] req_ext;

    // Widen the request vector, search from ptr+1, and decode the winner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        valid                = |req;
        idx                  = rr_next_idx(req_ext, ptr, NUM_REQ);
        onehot               = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            onehot[i] = valid && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/scratch_mem_arbiter.sv
// Round-robin, grant-held-until-release arbiter sharing the scratch memory
// write port (A) and read port (B) among NUM_REQ requesters, with the
// test-port override mux folded in. Read data fans out outside this block.
// Optional feature: define ARB_TIMEOUT_EN to add a hold counter that forces
// release after MAX_HOLD grant cycles and raises a sticky timeoutErr.
module scratch_mem_arbiter
    import scratch_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = SCRATCH_ADDR_W,
    parameter int DATA_W   = SCRATCH_DATA_W,
    parameter int MAX_HOLD = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] rdAddr,
    input  logic [NUM_REQ*ADDR_W-1:0] wrAddr,
    input  logic [NUM_REQ*DATA_W-1:0] wrData,
    input  logic [NUM_REQ-1:0]        wrEn,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [IDX_W-1:0]          gntIdx,
    output logic                      busy,
    input  logic                      testMuxSel,
    input  logic [ADDR_W-1:0]         testReadAddr,
    input  logic [ADDR_W-1:0]         testWriteAddr,
    input  logic [DATA_W-1:0]         testMemOut,
    input  logic                      testMemWriteEn,
    output logic [ADDR_W-1:0]         memReadAddr,
    output logic [ADDR_W-1:0]         memWriteAddr,
    output logic [DATA_W-1:0]         memWriteData,
    output logic                      memWriteEn
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                      timeoutErr
`endif
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               pick_valid;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_req;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = ($clog2(MAX_HOLD + 1) > 10) ? $clog2(MAX_HOLD + 1) : 10;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    scratch_mem_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // The owner still wants the bus; gnt_q is one-hot so a masked OR suffices.
    assign owner_req = |(req & gnt_q);

    // Next-state logic: arbitrate in IDLE, hold in GRANT until released.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d    = hold_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!testMuxSel && pick_valid) begin
                    state_d   = GRANT;
                    gnt_d     = pick_onehot;
                    gnt_idx_d = pick_idx;
                    rr_ptr_d  = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                hold_cnt_d = hold_cnt_q + 1'b1;
`endif
                // Test override or owner release both end the grant; the
                // return through IDLE gives the dead cycle between owners.
                if (testMuxSel || !owner_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt_d == HOLD_W'(MAX_HOLD)) begin
                    state_d       = IDLE;
                    gnt_d         = '0;
                    timeout_err_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset; rr_ptr starts at the top so
    // requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q    <= hold_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign gntIdx = gnt_idx_q;
    assign busy   = (state_q == GRANT);
`ifdef ARB_TIMEOUT_EN
    assign timeoutErr = timeout_err_q;
`endif

    // Memory port mux: test ports win; otherwise only the owner's slice
    // passes, so non-owners' wrEn can never reach the memory.
    always_comb begin
        memReadAddr  = '0;
        memWriteAddr = '0;
        memWriteData = '0;
        memWriteEn   = 1'b0;
        if (testMuxSel) begin
            memReadAddr  = testReadAddr;
            memWriteAddr = testWriteAddr;
            memWriteData = testMemOut;
            memWriteEn   = testMemWriteEn;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_q[i]) begin
                    memReadAddr  = rdAddr[i*ADDR_W +: ADDR_W];
                    memWriteAddr = wrAddr[i*ADDR_W +: ADDR_W];
                    memWriteData = wrData[i*DATA_W +: DATA_W];
                    memWriteEn   = wrEn[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Self-checking bench for scratch_mem_arbiter: directed scenarios plus a
// randomized run compared against a behavioural ownership model.
// Define ARB_TIMEOUT_EN to also exercise the hold-timeout feature.
`timescale 1ns/1ps
module tb_scratch_mem_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 8;

    typedef logic [2*ADDR_W+DATA_W:0] mem_vec_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] rdAddr;
    logic [NUM_REQ*ADDR_W-1:0] wrAddr;
    logic [NUM_REQ*DATA_W-1:0] wrData;
    logic [NUM_REQ-1:0]        wrEn;
    logic [NUM_REQ-1:0]        gnt;
    logic [2:0]                gntIdx;
    logic                      busy;
    logic                      testMuxSel;
    logic [ADDR_W-1:0]         testReadAddr;
    logic [ADDR_W-1:0]         testWriteAddr;
    logic [DATA_W-1:0]         testMemOut;
    logic                      testMemWriteEn;
    logic [ADDR_W-1:0]         memReadAddr;
    logic [ADDR_W-1:0]         memWriteAddr;
    logic [DATA_W-1:0]         memWriteData;
    logic                      memWriteEn;
`ifdef ARB_TIMEOUT_EN
    logic                      timeoutErr;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Small scratch memory fed by the arbiter's write port.
    logic [DATA_W-1:0] tb_mem [0:255];

    // Behavioural model: who owns the bus and who owned it last.
    int m_owner;
    int m_last;
    int m_hold;
    bit m_terr;

    mem_vec_t dut_mem;
    assign dut_mem = {memReadAddr, memWriteAddr, memWriteData, memWriteEn};

    scratch_mem_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .rdAddr         (rdAddr),
        .wrAddr         (wrAddr),
        .wrData         (wrData),
        .wrEn           (wrEn),
        .gnt            (gnt),
        .gntIdx         (gntIdx),
        .busy           (busy),
        .testMuxSel     (testMuxSel),
        .testReadAddr   (testReadAddr),
        .testWriteAddr  (testWriteAddr),
        .testMemOut     (testMemOut),
        .testMemWriteEn (testMemWriteEn),
        .memReadAddr    (memReadAddr),
        .memWriteAddr   (memWriteAddr),
        .memWriteData   (memWriteData),
        .memWriteEn     (memWriteEn)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeoutErr     (timeoutErr)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memWriteEn) tb_mem[memWriteAddr[7:0]] <= memWriteData;
    end

    // ---------------- reference model ----------------
    function automatic logic [NUM_REQ-1:0] m_gnt();
        logic [NUM_REQ-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic mem_vec_t m_mem();
        if (testMuxSel) return {testReadAddr, testWriteAddr, testMemOut, testMemWriteEn};
        if (m_owner < 0) return '0;
        return {rdAddr[m_owner*ADDR_W +: ADDR_W], wrAddr[m_owner*ADDR_W +: ADDR_W],
                wrData[m_owner*DATA_W +: DATA_W], wrEn[m_owner]};
    endfunction

    // Apply the arbitration rules for one clock edge using current inputs.
    task automatic model_edge();
        bit rel;
        int c;
        if (reset) begin
            m_owner = -1;
            m_last  = NUM_REQ - 1;
            m_hold  = 0;
            m_terr  = 0;
        end else if (m_owner >= 0) begin
            rel = testMuxSel || !req[m_owner];
`ifdef ARB_TIMEOUT_EN
            m_hold++;
            if (!rel && m_hold >= MAX_HOLD) begin
                rel    = 1;
                m_terr = 1;
            end
`endif
            if (rel) m_owner = -1;
        end else if (!testMuxSel && req != '0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (m_last + k) % NUM_REQ;
                if (m_owner < 0 && req[c]) m_owner = c;
            end
            m_last = m_owner;
            m_hold = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; req = '0; wrEn = '0; rdAddr = '0; wrAddr = '0; wrData = '0;
        testMuxSel = 1'b0; testReadAddr = '0; testWriteAddr = '0; testMemOut = '0; testMemWriteEn = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (gnt !== 4'b0000) begin n_fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (gntIdx !== 3'd0) begin n_fails++; $display("FAIL reset_gntIdx: got %0d want 0", gntIdx); end
        n_checks++; if (dut_mem !== '0) begin n_fails++; $display("FAIL reset_mem: got %h want 0", dut_mem); end
`ifdef ARB_TIMEOUT_EN
        n_checks++; if (timeoutErr !== 1'b0) begin n_fails++; $display("FAIL reset_timeoutErr: got %b want 0", timeoutErr); end
`endif
    endtask

    task automatic test_single();
        apply_reset();
        rdAddr = '0;
        rdAddr[2*ADDR_W +: ADDR_W] = 12'h0A5;
        req = 4'b0100;
        #1;
        n_checks++; if (gnt !== 4'b0000) begin n_fails++; $display("FAIL single_latency: got %b want 0000", gnt); end
        tick();
        n_checks++; if (gnt !== 4'b0100) begin n_fails++; $display("FAIL single_gnt: got %b want 0100", gnt); end
        n_checks++; if (busy !== 1'b1 || gntIdx !== 3'd2) begin n_fails++; $display("FAIL single_owner: got busy=%b idx=%0d want 1/2", busy, gntIdx); end
        n_checks++; if (memReadAddr !== 12'h0A5) begin n_fails++; $display("FAIL single_rdaddr: got %h want 0a5", memReadAddr); end
        req = 4'b0000;
        tick();
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fails++; $display("FAIL single_release: got gnt=%b busy=%b want 0000/0", gnt, busy); end
        n_checks++; if (memReadAddr !== 12'h000) begin n_fails++; $display("FAIL single_idle_mux: got %h want 000", memReadAddr); end
    endtask

    task automatic test_round_robin();
        int seq[$];
        int exp_seq[5];
        int held;
        int idle_run;
        exp_seq = '{0, 1, 2, 3, 0};
        held = 0;
        idle_run = 0;
        apply_reset();
        req = 4'b1111;
        for (int c = 0; c < 40 && seq.size() < 5; c++) begin
            tick();
            n_checks++;
            if (gnt !== m_gnt()) begin n_fails++; $display("FAIL rr_model cycle %0d: got %b want %b", c, gnt, m_gnt()); end
            if (busy) begin
                if (held == 0) begin
                    seq.push_back(int'(gntIdx));
                    if (seq.size() > 1) begin
                        n_checks++;
                        if (idle_run != 1) begin n_fails++; $display("FAIL rr_dead_cycle: got %0d idle cycles want 1", idle_run); end
                    end
                end
                held++;
                idle_run = 0;
            end else begin
                held = 0;
                idle_run++;
            end
            req = 4'b1111;
            if (busy && held == 3) req[gntIdx] = 1'b0;
        end
        n_checks++;
        if (seq.size() != 5) begin
            n_fails++; $display("FAIL rr_count: got %0d grants want 5", seq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (seq[i] != exp_seq[i]) begin n_fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, seq[i], exp_seq[i]); end
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_write_gating();
        apply_reset();
        wrEn = '0;
        wrAddr[1*ADDR_W +: ADDR_W] = 12'h020;
        wrData[1*DATA_W +: DATA_W] = 32'hCAFE_0001;
        req = 4'b0010;
        tick();
        n_checks++; if (gnt !== 4'b0010) begin n_fails++; $display("FAIL wg_gnt: got %b want 0010", gnt); end
        wrAddr[3*ADDR_W +: ADDR_W] = 12'h010;
        wrData[3*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        wrEn = 4'b1000;
        req = 4'b1010;
        #1;
        n_checks++; if (memWriteEn !== 1'b0) begin n_fails++; $display("FAIL wg_we_nonowner: got %b want 0", memWriteEn); end
        n_checks++; if (memWriteAddr !== 12'h020) begin n_fails++; $display("FAIL wg_waddr: got %h want 020", memWriteAddr); end
        tick();
        tick();
        n_checks++; if (gnt !== 4'b0010) begin n_fails++; $display("FAIL wg_no_preempt: got %b want 0010", gnt); end
        n_checks++; if (tb_mem[8'h10] !== 32'h0) begin n_fails++; $display("FAIL wg_mem10: got %h want 0", tb_mem[8'h10]); end
        wrEn = 4'b1010;
        wrAddr[1*ADDR_W +: ADDR_W] = 12'h011;
        wrData[1*DATA_W +: DATA_W] = 32'h1234_5678;
        #1;
        n_checks++; if (memWriteEn !== 1'b1 || memWriteData !== 32'h1234_5678) begin n_fails++; $display("FAIL wg_owner_write: got we=%b d=%h want 1/12345678", memWriteEn, memWriteData); end
        tick();
        n_checks++; if (tb_mem[8'h11] !== 32'h1234_5678) begin n_fails++; $display("FAIL wg_mem11: got %h want 12345678", tb_mem[8'h11]); end
        wrEn = '0;
        req = '0;
        tick();
        tick();
        n_checks++; if (tb_mem[8'h10] !== 32'h0) begin n_fails++; $display("FAIL wg_mem10_end: got %h want 0", tb_mem[8'h10]); end
    endtask

    task automatic test_override();
        apply_reset();
        wrEn = '0;
        wrAddr[0 +: ADDR_W] = 12'h040;
        wrData[0 +: DATA_W] = 32'h1111_1111;
        req = 4'b0001;
        tick();
        n_checks++; if (gnt !== 4'b0001) begin n_fails++; $display("FAIL ov_gnt: got %b want 0001", gnt); end
        testMuxSel = 1'b1; testWriteAddr = 12'h123; testMemOut = 32'h0000_55AA;
        testMemWriteEn = 1'b1; testReadAddr = 12'h777; wrEn = 4'b0001;
        #1;
        n_checks++; if (dut_mem !== {12'h777, 12'h123, 32'h0000_55AA, 1'b1}) begin n_fails++; $display("FAIL ov_mux: got %h want test ports", dut_mem); end
        n_checks++; if (gnt !== 4'b0001) begin n_fails++; $display("FAIL ov_gnt_hold: got %b want 0001", gnt); end
        tick();
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fails++; $display("FAIL ov_release: got gnt=%b busy=%b want 0000/0", gnt, busy); end
        n_checks++; if (tb_mem[8'h23] !== 32'h0000_55AA) begin n_fails++; $display("FAIL ov_mem23: got %h want 55aa", tb_mem[8'h23]); end
        n_checks++; if (tb_mem[8'h40] !== 32'h0) begin n_fails++; $display("FAIL ov_mem40: got %h want 0", tb_mem[8'h40]); end
        tick();
        tick();
        n_checks++; if (gnt !== 4'b0000) begin n_fails++; $display("FAIL ov_no_grant: got %b want 0000", gnt); end
        testMuxSel = 1'b0; testMemWriteEn = 1'b0; wrEn = '0;
        tick();
        n_checks++; if (gnt !== 4'b0001) begin n_fails++; $display("FAIL ov_resume: got %b want 0001", gnt); end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        wrEn = '0;
        req = 4'b0100;
        tick();
        n_checks++; if (gnt !== 4'b0100) begin n_fails++; $display("FAIL rmg_gnt: got %b want 0100", gnt); end
        wrEn = 4'b0100;
        wrAddr[2*ADDR_W +: ADDR_W] = 12'h0F0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fails++; $display("FAIL rmg_drop: got gnt=%b busy=%b want 0000/0", gnt, busy); end
        n_checks++; if (memWriteEn !== 1'b0) begin n_fails++; $display("FAIL rmg_we: got %b want 0", memWriteEn); end
        wrEn = '0;
        req = 4'b1111;
        tick();
        n_checks++; if (gnt !== 4'b0001 || gntIdx !== 3'd0) begin n_fails++; $display("FAIL rmg_first: got gnt=%b idx=%0d want 0001/0", gnt, gntIdx); end
        req = '0;
        tick();
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int held;
        apply_reset();
        wrEn = '0;
        req = 4'b0011;
        tick();
        n_checks++; if (gnt !== 4'b0001 || timeoutErr !== 1'b0) begin n_fails++; $display("FAIL to_start: got gnt=%b err=%b want 0001/0", gnt, timeoutErr); end
        held = 1;
        for (int c = 0; c < 3*MAX_HOLD; c++) begin
            tick();
            if (gnt !== 4'b0001) break;
            held++;
        end
        n_checks++; if (held != MAX_HOLD) begin n_fails++; $display("FAIL to_hold: got %0d cycles want %0d", held, MAX_HOLD); end
        n_checks++; if (timeoutErr !== 1'b1 || busy !== 1'b0) begin n_fails++; $display("FAIL to_flag: got err=%b busy=%b want 1/0", timeoutErr, busy); end
        tick();
        n_checks++; if (gnt !== 4'b0010) begin n_fails++; $display("FAIL to_next: got %b want 0010", gnt); end
        req = '0;
        tick();
        tick();
        n_checks++; if (timeoutErr !== 1'b1) begin n_fails++; $display("FAIL to_sticky: got %b want 1", timeoutErr); end
    endtask
`endif

    task automatic test_random();
        apply_reset();
        req = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(3) == 0) req[i] = ~req[i];
                rdAddr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                wrAddr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                wrData[i*DATA_W +: DATA_W] = $urandom;
            end
            wrEn           = NUM_REQ'($urandom);
            testMuxSel     = ($urandom_range(15) == 0);
            testReadAddr   = ADDR_W'($urandom);
            testWriteAddr  = ADDR_W'($urandom);
            testMemOut     = $urandom;
            testMemWriteEn = 1'($urandom);
            #1;
            n_checks++;
            if (dut_mem !== m_mem()) begin n_fails++; $display("FAIL rand_mux cycle %0d: got %h want %h", c, dut_mem, m_mem()); end
            tick();
            n_checks++;
            if (gnt !== m_gnt() || busy !== (m_owner >= 0)) begin
                n_fails++; $display("FAIL rand_gnt cycle %0d: got gnt=%b busy=%b want %b/%b", c, gnt, busy, m_gnt(), (m_owner >= 0));
            end
            if (m_owner >= 0) begin
                n_checks++;
                if (int'(gntIdx) != m_owner) begin n_fails++; $display("FAIL rand_idx cycle %0d: got %0d want %0d", c, gntIdx, m_owner); end
            end
`ifdef ARB_TIMEOUT_EN
            n_checks++;
            if (timeoutErr !== m_terr) begin n_fails++; $display("FAIL rand_terr cycle %0d: got %b want %b", c, timeoutErr, m_terr); end
`endif
        end
        testMuxSel = 1'b0;
        req = '0;
        wrEn = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = '0;
        m_owner = -1;
        m_last  = NUM_REQ - 1;
        m_hold  = 0;
        m_terr  = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_write_gating();
        test_override();
        test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/scratch_mem_arbiter.md
Name: scratch_mem_arbiter

Overview:
- Shares the single Scratch_Memory_Controller port pair (write port A, read port B) among NUM_REQ sub-FSMs of an encoder stage (e.g. LSP quantizer sub-blocks). It uses a round-robin, grant-held-until-release scheme.
- Includes the test-bench override mux, so the stage wrapper instantiates one arbiter instead of per-signal muxes.
- Read data (doutb) fans out directly to all requesters and is not routed through this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 12, scratch memory address width
- DATA_W, 32, scratch memory data width
- MAX_HOLD, 1023, maximum grant hold cycles; only used with ARB_TIMEOUT_EN

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester bus request; bit i = requester i
- rdAddr  in  NUM_REQ*ADDR_W  read addresses; slice i = requester i
- wrAddr  in  NUM_REQ*ADDR_W  write addresses, packed the same way
- wrData  in  NUM_REQ*DATA_W  write data, packed the same way
- wrEn  in  NUM_REQ  per-requester write enable
- gnt  out  NUM_REQ  one-hot grant
- gntIdx  out  3  index of the current owner; valid while busy=1
- busy  out  1  a grant is active
- testMuxSel  in  1  1 = test ports drive the memory
- testReadAddr  in  ADDR_W  test read address
- testWriteAddr  in  ADDR_W  test write address
- testMemOut  in  DATA_W  test write data
- testMemWriteEn  in  1  test write enable
- memReadAddr  out  ADDR_W  to memory addrb
- memWriteAddr  out  ADDR_W  to memory addra
- memWriteData  out  DATA_W  to memory dina
- memWriteEn  out  1  to memory wea
- timeoutErr  out  1  sticky error flag; only present with ARB_TIMEOUT_EN

Behaviour:
- Reset values (synchronous, when reset=1 at a clk edge):
  - gnt=0, gntIdx=0, busy=0, state=IDLE
  - rrPtr = NUM_REQ-1, so requester 0 has first priority after reset
  - timeoutErr=0
- Reset mid-grant drops gnt on the same edge; no write is issued in the following cycle.
- FSM state IDLE:
  - If testMuxSel=0 and req≠0, select the first set req bit scanning from (rrPtr+1) mod NUM_REQ upward with wrap.
  - On the next edge: gnt[sel]=1, gntIdx=sel, busy=1, rrPtr=sel, go to GRANT.
  - Latency from req rising to gnt is 1 cycle.
- FSM state GRANT:
  - Hold the grant while req[gntIdx]=1.
  - When req[gntIdx]=0 is sampled at an edge, clear gnt/busy on that edge and return to IDLE.
  - The next grant comes at the earliest on the following edge. This leaves one guaranteed dead cycle between owners, with no overlap.
  - Requests from other requesters do not preempt the owner.
- Simultaneous requests: round-robin order from rrPtr+1. The last owner has lowest priority on the next arbitration.
- Output mux (combinational) when testMuxSel=0 and busy=1:
  - memReadAddr / memWriteAddr / memWriteData = slice gntIdx of rdAddr / wrAddr / wrData
  - memWriteEn = wrEn[gntIdx]
- Output mux when testMuxSel=0 and busy=0:
  - all address and data outputs = 0
  - memWriteEn=0; wrEn from non-owners is ignored
- testMuxSel=1:
  - outputs driven from the test ports
  - FSM forced to IDLE at the next edge; gnt=0 and busy=0 from that edge
  - no grants issued while testMuxSel=1
  - during the transition cycle, the owner's writes are suppressed because the test path overrides the mux
- A requester must not drive wrEn before it sees gnt. A requester dropping req while not granted has no effect.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A hold counter (10+ bits) clears on each new grant and increments each GRANT cycle.
  - When it reaches MAX_HOLD, the grant is forcibly released (to IDLE) and timeoutErr is set.
  - timeoutErr is sticky until reset.
  - If the released requester still holds req, it re-competes at normal round-robin priority.
- ARB_TIMEOUT_EN not defined:
  - no counter; grants are held indefinitely
  - timeoutErr port absent

Decomposition:
- Shared package holds:
  - state encodings IDLE=1'b0, GRANT=1'b1
  - SCRATCH_ADDR_W=12, SCRATCH_DATA_W=32
  - a function for round-robin next-index selection
- Natural sub-module: rr_pick (combinational round-robin selector: req vector + pointer → one-hot + index). It is reusable for a later shared-math-unit arbiter.

Test Plan:
- Single request: reset, then req=4'b0100 with rdAddr slice2=12'h0A5 → gnt=4'b0100 one cycle later; memReadAddr=0x0A5. Drop req → gnt=0 next edge.
- Round-robin with all requesting: req=4'b1111, each owner holds 3 cycles then drops and re-raises → grant order 0,1,2,3,0, with one idle cycle between grants.
- Write gating: requester1 owns the bus, requester3 drives wrEn=1, wrAddr=0x010, wrData=0xDEADBEEF → memWriteEn reflects only wrEn[1]. Memory read at 0x010 shows no write from requester3.
- Test override: mid-grant, set testMuxSel=1 with testWriteAddr=0x123, testMemOut=0x55AA, testMemWriteEn=1 → memory outputs follow the test ports immediately and gnt=0 next edge. Clear testMuxSel → normal arbitration resumes.
- Reset mid-grant: assert reset while requester2 owns the bus → gnt=0, busy=0, memWriteEn=0 the next cycle. After reset with req=4'b1111, requester0 is granted first.
- With ARB_TIMEOUT_EN and MAX_HOLD=8: hold req0 constantly → forced release after 8 grant cycles, timeoutErr=1 (sticky). If req1 is pending, requester1 is granted next.
